// File: rtl/cpu_pkg.sv
// Shared opcode, state and control-word definitions for the accumulator CPU sequencer.
// Control-word bit indices are used by ctrl_rom and ctrl_sequencer.
package cpu_pkg;

   localparam int OPCODE_W = 3;

   localparam logic [OPCODE_W-1:0] OP_NOP = 3'b000;
   localparam logic [OPCODE_W-1:0] OP_ADD = 3'b001;
   localparam logic [OPCODE_W-1:0] OP_LDA = 3'b010;
   localparam logic [OPCODE_W-1:0] OP_STA = 3'b011;
   localparam logic [OPCODE_W-1:0] OP_JMP = 3'b100;
   localparam logic [OPCODE_W-1:0] OP_JZ  = 3'b101;
   localparam logic [OPCODE_W-1:0] OP_JC  = 3'b110;
   localparam logic [OPCODE_W-1:0] OP_HLT = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T0   = 3'd1,
      ST_T1   = 3'd2,
      ST_T2   = 3'd3,
      ST_T3   = 3'd4,
      ST_T4   = 3'd5,
      ST_HALT = 3'd6,
      ST_STEP = 3'd7
   } state_t;

   localparam int CW_PC_OE    = 0;
   localparam int CW_PC_INC   = 1;
   localparam int CW_PC_LD    = 2;
   localparam int CW_MAR_LD   = 3;
   localparam int CW_IR_LD    = 4;
   localparam int CW_IR_OE    = 5;
   localparam int CW_MEM_OE   = 6;
   localparam int CW_MEM_WE   = 7;
   localparam int CW_ACC_LD   = 8;
   localparam int CW_ACC_OE   = 9;
   localparam int CW_B_LD     = 10;
   localparam int CW_ALU_OE   = 11;
   localparam int CW_FLAGS_LD = 12;
   localparam int CW_JMP      = 13;
   localparam int CW_DONE     = 14;
   localparam int CW_HALTED   = 15;
   localparam int CW_W        = 16;

   typedef logic [CW_W-1:0] cw_t;

   function automatic logic is_jump(input logic [OPCODE_W-1:0] op);
      return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
   endfunction

   function automatic logic has_mem_phase(input logic [OPCODE_W-1:0] op);
      return (op == OP_LDA) || (op == OP_ADD) || (op == OP_STA);
   endfunction

endpackage

// File: rtl/ctrl_rom.sv
// Combinational control store: (state, opcode) -> control word.
// The pc_ld bit is a request only; the sequencer gates it with the branch unit output.
module ctrl_rom
   import cpu_pkg::*;
(
   input  state_t              state,
   input  logic [OPCODE_W-1:0] op,
   output cw_t                 cw
);

   always_comb begin
      cw = '0;
      case (state)
         ST_T0: begin
            cw[CW_PC_OE]  = 1'b1;
            cw[CW_MAR_LD] = 1'b1;
         end
         ST_T1: begin
            cw[CW_MEM_OE] = 1'b1;
            cw[CW_IR_LD]  = 1'b1;
            cw[CW_PC_INC] = 1'b1;
         end
         ST_T2: begin
            if (is_jump(op)) begin
               cw[CW_JMP]   = 1'b1;
               cw[CW_IR_OE] = 1'b1;
               cw[CW_PC_LD] = 1'b1;
               cw[CW_DONE]  = 1'b1;
            end else if (has_mem_phase(op)) begin
               cw[CW_IR_OE]  = 1'b1;
               cw[CW_MAR_LD] = 1'b1;
            end else begin
               cw[CW_DONE] = 1'b1;
            end
         end
         ST_T3: begin
            case (op)
               OP_LDA: begin
                  cw[CW_MEM_OE] = 1'b1;
                  cw[CW_ACC_LD] = 1'b1;
                  cw[CW_DONE]   = 1'b1;
               end
               OP_STA: begin
                  cw[CW_ACC_OE] = 1'b1;
                  cw[CW_MEM_WE] = 1'b1;
                  cw[CW_DONE]   = 1'b1;
               end
               OP_ADD: begin
                  cw[CW_MEM_OE] = 1'b1;
                  cw[CW_B_LD]   = 1'b1;
               end
               default: cw = '0;
            endcase
         end
         ST_T4: begin
            cw[CW_ALU_OE]   = 1'b1;
            cw[CW_ACC_LD]   = 1'b1;
            cw[CW_FLAGS_LD] = 1'b1;
            cw[CW_DONE]     = 1'b1;
         end
         ST_HALT: cw[CW_HALTED] = 1'b1;
         default: cw = '0;
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Microsequencer for the 8-bit accumulator CPU: steps T-states and drives datapath control.
// Define SINGLE_STEP_EN to add step_i and a STEP state that waits for a step_i rising edge.
//
// state | meaning
// IDLE  | parked, waiting for run_i
// T0    | PC -> MAR
// T1    | memory -> IR, PC increment
// T2    | decode; jumps/NOP/HLT finish here
// T3    | LDA/STA finish, ADD fetches operand into B
// T4    | ADD writes ALU result and flags
// HALT  | sticky until reset
// STEP  | single-step wait (SINGLE_STEP_EN only)
module ctrl_sequencer
   import cpu_pkg::*;
#(
   parameter int OP_W = OPCODE_W
)(
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            run_i,
   input  logic [OP_W-1:0] op_i,
   input  logic            branch_i,
`ifdef SINGLE_STEP_EN
   input  logic            step_i,
`endif
   output logic            pc_oe_o,
   output logic            pc_inc_o,
   output logic            pc_ld_o,
   output logic            mar_ld_o,
   output logic            ir_ld_o,
   output logic            ir_oe_o,
   output logic            mem_oe_o,
   output logic            mem_we_o,
   output logic            acc_ld_o,
   output logic            acc_oe_o,
   output logic            b_ld_o,
   output logic            alu_oe_o,
   output logic            flags_ld_o,
   output logic            ctrl_jmp_o,
   output logic            instr_done_o,
   output logic            halted_o
);

   state_t state;
   state_t after_done;
   cw_t    cw;

`ifdef SINGLE_STEP_EN
   logic step_q;
   logic step_rise;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) step_q <= 1'b0;
      else          step_q <= step_i;
   end

   assign step_rise  = step_i & ~step_q;
   assign after_done = ST_STEP;
`else
   assign after_done = run_i ? ST_T0 : ST_IDLE;
`endif

   // run_i is only consulted at IDLE and at instruction completion, never mid-instruction.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (run_i) state <= ST_T0;
            ST_T0:   state <= ST_T1;
            ST_T1:   state <= ST_T2;
            ST_T2: begin
               if (op_i == OP_HLT)          state <= ST_HALT;
               else if (has_mem_phase(op_i)) state <= ST_T3;
               else                          state <= after_done;
            end
            ST_T3:   state <= (op_i == OP_ADD) ? ST_T4 : after_done;
            ST_T4:   state <= after_done;
            ST_HALT: state <= ST_HALT;
`ifdef SINGLE_STEP_EN
            ST_STEP: if (step_rise) state <= run_i ? ST_T0 : ST_IDLE;
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode the state register directly: op_i is only valid from T2, so the
   // control word cannot be precomputed a cycle early, and reset clears it asynchronously.
   ctrl_rom u_rom (
      .state (state),
      .op    (op_i),
      .cw    (cw)
   );

   assign pc_oe_o      = cw[CW_PC_OE];
   assign pc_inc_o     = cw[CW_PC_INC];
   assign pc_ld_o      = cw[CW_PC_LD] & branch_i;
   assign mar_ld_o     = cw[CW_MAR_LD];
   assign ir_ld_o      = cw[CW_IR_LD];
   assign ir_oe_o      = cw[CW_IR_OE];
   assign mem_oe_o     = cw[CW_MEM_OE];
   assign mem_we_o     = cw[CW_MEM_WE];
   assign acc_ld_o     = cw[CW_ACC_LD];
   assign acc_oe_o     = cw[CW_ACC_OE];
   assign b_ld_o       = cw[CW_B_LD];
   assign alu_oe_o     = cw[CW_ALU_OE];
   assign flags_ld_o   = cw[CW_FLAGS_LD];
   assign ctrl_jmp_o   = cw[CW_JMP];
   assign instr_done_o = cw[CW_DONE];
   assign halted_o     = cw[CW_HALTED];

   bus_single_driver: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      $onehot0({pc_oe_o, ir_oe_o, mem_oe_o, acc_oe_o, alu_oe_o}));

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: per-instruction expected T-state traces are queued at
// issue time and compared by an independent monitor at every instr_done_o pulse.
module tb_ctrl_sequencer;

   typedef logic [14:0] word_t;

   localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b001, OP_LDA = 3'b010, OP_STA = 3'b011;
   localparam logic [2:0] OP_JMP = 3'b100, OP_JZ  = 3'b101, OP_JC  = 3'b110, OP_HLT = 3'b111;

   localparam word_t W_PC_OE  = 15'h4000, W_PC_INC = 15'h2000, W_PC_LD  = 15'h1000;
   localparam word_t W_MAR_LD = 15'h0800, W_IR_LD  = 15'h0400, W_IR_OE  = 15'h0200;
   localparam word_t W_MEM_OE = 15'h0100, W_MEM_WE = 15'h0080, W_ACC_LD = 15'h0040;
   localparam word_t W_ACC_OE = 15'h0020, W_B_LD   = 15'h0010, W_ALU_OE = 15'h0008;
   localparam word_t W_FLAGS  = 15'h0004, W_JMP    = 15'h0002, W_DONE   = 15'h0001;

   logic       clk_i, rst_n_i, run_i, branch_i;
   logic [2:0] op_i;
`ifdef SINGLE_STEP_EN
   logic       step_i;
`endif
   logic pc_oe_o, pc_inc_o, pc_ld_o, mar_ld_o, ir_ld_o, ir_oe_o, mem_oe_o, mem_we_o;
   logic acc_ld_o, acc_oe_o, b_ld_o, alu_oe_o, flags_ld_o, ctrl_jmp_o, instr_done_o, halted_o;

   int    vectors = 0;
   int    miscompares = 0;
   int    lat_tab [8] = '{3, 5, 4, 4, 3, 3, 3, 3};
   word_t exp_words [$];
   int    exp_len [$];
   word_t trace [$];

   ctrl_sequencer dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .run_i(run_i), .op_i(op_i), .branch_i(branch_i),
`ifdef SINGLE_STEP_EN
      .step_i(step_i),
`endif
      .pc_oe_o(pc_oe_o), .pc_inc_o(pc_inc_o), .pc_ld_o(pc_ld_o), .mar_ld_o(mar_ld_o),
      .ir_ld_o(ir_ld_o), .ir_oe_o(ir_oe_o), .mem_oe_o(mem_oe_o), .mem_we_o(mem_we_o),
      .acc_ld_o(acc_ld_o), .acc_oe_o(acc_oe_o), .b_ld_o(b_ld_o), .alu_oe_o(alu_oe_o),
      .flags_ld_o(flags_ld_o), .ctrl_jmp_o(ctrl_jmp_o), .instr_done_o(instr_done_o),
      .halted_o(halted_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic word_t cur_word();
      return {pc_oe_o, pc_inc_o, pc_ld_o, mar_ld_o, ir_ld_o, ir_oe_o, mem_oe_o, mem_we_o,
              acc_ld_o, acc_oe_o, b_ld_o, alu_oe_o, flags_ld_o, ctrl_jmp_o, instr_done_o};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each instruction is a fixed list of per-T-state control words.
   task automatic push_expect(input logic [2:0] op, input logic br);
      word_t seq [$];
      seq.push_back(W_PC_OE | W_MAR_LD);
      seq.push_back(W_MEM_OE | W_IR_LD | W_PC_INC);
      case (op)
         OP_NOP, OP_HLT:      seq.push_back(W_DONE);
         OP_JMP, OP_JZ, OP_JC: seq.push_back(W_JMP | W_IR_OE | W_DONE | (br ? W_PC_LD : 15'h0));
         OP_LDA: begin
            seq.push_back(W_IR_OE | W_MAR_LD);
            seq.push_back(W_MEM_OE | W_ACC_LD | W_DONE);
         end
         OP_STA: begin
            seq.push_back(W_IR_OE | W_MAR_LD);
            seq.push_back(W_ACC_OE | W_MEM_WE | W_DONE);
         end
         default: begin
            seq.push_back(W_IR_OE | W_MAR_LD);
            seq.push_back(W_MEM_OE | W_B_LD);
            seq.push_back(W_ALU_OE | W_ACC_LD | W_FLAGS | W_DONE);
         end
      endcase
      exp_len.push_back(lat_tab[op]);
      foreach (seq[i]) exp_words.push_back(seq[i]);
   endtask

   // Monitor: gathers non-idle words and checks the whole instruction at its done pulse.
   initial begin
      word_t w, w_exp;
      int    n;
      forever begin
         @(negedge clk_i);
         if (!rst_n_i) begin
            trace.delete();
         end else begin
            w = cur_word();
            if (w != 15'h0) trace.push_back(w);
            if (instr_done_o) begin
               if (exp_len.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL sb_underflow: instr_done_o with nothing expected at %0t", $time);
               end else begin
                  n = exp_len.pop_front();
                  chk("instr_cycles", 32'(trace.size()), 32'(n));
                  for (int i = 0; i < n; i++) begin
                     w_exp = exp_words.pop_front();
                     chk($sformatf("tstate%0d_word", i),
                         (i < trace.size()) ? 32'(trace[i]) : 32'hffff_ffff, 32'(w_exp));
                  end
               end
               trace.delete();
            end
         end
      end
   end

   task automatic start(input logic [2:0] op, input logic br);
      op_i     = op;
      branch_i = br;
      push_expect(op, br);
   endtask

   task automatic wait_done();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         @(negedge clk_i);
         seen = instr_done_o;
      end
      chk("done_within_budget", 32'(seen), 32'd1);
   endtask

   task automatic finish_gap();
      @(posedge clk_i); #1;
`ifdef SINGLE_STEP_EN
      step_i = 1'b0;
      @(posedge clk_i); #1;
      step_i = 1'b1;
      @(posedge clk_i); #1;
`endif
   endtask

   // Called just after a clock edge with the DUT in IDLE or T0.
   task automatic issue(input logic [2:0] op, input logic br, input logic drop);
      start(op, br);
      if (drop) begin
         @(posedge clk_i); #1;
         run_i = 1'b0;
      end
      wait_done();
      finish_gap();
      if (drop) begin
         repeat (4) begin
            @(negedge clk_i);
            chk("parked_idle", 32'({halted_o, cur_word()}), 32'd0);
         end
         @(posedge clk_i); #1;
         run_i = 1'b1;
      end
   endtask

   initial begin
      int cnt;
      logic [2:0] op;
      logic br, drop;
      rst_n_i = 1'b0; run_i = 1'b0; op_i = 3'b000; branch_i = 1'b0;
`ifdef SINGLE_STEP_EN
      step_i = 1'b1;
`endif
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_word", 32'(cur_word()), 32'd0);
      chk("reset_halted", 32'(halted_o), 32'd0);
      rst_n_i = 1'b1;
      repeat (3) begin
         @(negedge clk_i);
         chk("idle_without_run", 32'(cur_word()), 32'd0);
      end
      @(posedge clk_i); #1;
      run_i = 1'b1;

      issue(OP_LDA, 1'b0, 1'b0);
      issue(OP_ADD, 1'b1, 1'b0);
      issue(OP_STA, 1'b1, 1'b0);
      issue(OP_NOP, 1'b1, 1'b0);
      issue(OP_JZ,  1'b1, 1'b0);
      issue(OP_JZ,  1'b0, 1'b0);
      issue(OP_JC,  1'b1, 1'b0);
      issue(OP_JC,  1'b0, 1'b0);
      issue(OP_JMP, 1'b1, 1'b0);
      issue(OP_JMP, 1'b0, 1'b0);
      issue(OP_ADD, 1'b0, 1'b1);

      for (int k = 0; k < 60; k++) begin
         op   = 3'($urandom_range(0, 6));
         br   = 1'($urandom_range(0, 1));
         drop = ($urandom_range(0, 7) == 0);
         issue(op, br, drop);
      end

      // Reset asserted in the middle of STA's T3 (the write strobe cycle).
      start(OP_STA, 1'b0);
      wait_done();
      #2 rst_n_i = 1'b0;
      #1;
      chk("reset_async_word", 32'(cur_word()), 32'd0);
      chk("reset_async_we", 32'(mem_we_o), 32'd0);
      @(negedge clk_i); #1;
      rst_n_i = 1'b1;
      chk("release_idle", 32'(cur_word()), 32'd0);
      start(OP_NOP, 1'b0);
      @(posedge clk_i); #1;
      chk("t0_after_release", 32'(cur_word()), 32'(W_PC_OE | W_MAR_LD));
      wait_done();
      finish_gap();

`ifdef SINGLE_STEP_EN
      start(OP_NOP, 1'b0);
      wait_done();
      cnt = 0;
      repeat (20) begin
         @(negedge clk_i);
         if (instr_done_o) cnt++;
      end
      chk("step_held_one_instr", 32'(cnt), 32'd0);
      finish_gap();
      issue(OP_ADD, 1'b0, 1'b1);
`endif

      start(OP_HLT, 1'b0);
      wait_done();
      @(posedge clk_i); #1;
      chk("halt_entry", 32'(halted_o), 32'd1);
      repeat (100) begin
         @(posedge clk_i); #1;
         run_i = 1'($urandom_range(0, 1));
         @(negedge clk_i);
         chk("halt_sticky", 32'({halted_o, cur_word()}), 32'h8000);
      end
      chk("scoreboard_empty", 32'(exp_len.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
